// File: rtl/fs_accel_config_loader.sv
// Descriptor-driven sequencer: fetches a per-layer descriptor and replays it as config register writes.
// Optional trailing-checksum verification is enabled with `define FS_CFG_LOADER_CHECKSUM_EN.
module fs_accel_config_loader #(
    parameter int MAX_QCH     = 36,
    parameter int ADDR_STRIDE = 4
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [31:0] i_desc_base_addr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_config_wen,
    output logic [4:0]  o_config_sel,
    output logic [31:0] o_config_data
);

    localparam logic [5:0]  LP_MAX_QCH = 6'(MAX_QCH);
    localparam logic [31:0] LP_STRIDE  = 32'(ADDR_STRIDE);
    localparam logic [6:0]  LP_K_QCH   = 7'd16;
    localparam logic [6:0]  LP_K_CH0   = 7'd17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WR,
        S_QIDX,
        S_DONE
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_base,  w_base_next;
    logic [6:0]  r_k,     w_k_next;
    logic [5:0]  r_qch,   w_qch_next;
    logic [5:0]  r_ch,    w_ch_next;
    logic [31:0] r_data,  w_data_next;
    logic        r_error, w_error_next;

    logic        w_is_cfg;
    logic        w_is_qword;
    logic        w_is_csum;
    logic [4:0]  w_cfg_sel;
    logic        w_last_ch;

`ifdef FS_CFG_LOADER_CHECKSUM_EN
    logic [31:0] r_xor, w_xor_next;
    // The checksum word sits right after the last shift word (or after word 16 when qch=0).
    assign w_is_csum = (r_k == (LP_K_CH0 + {r_qch, 1'b0}));
`else
    assign w_is_csum = 1'b0;
`endif

    assign w_is_cfg   = (r_k < LP_K_QCH);
    assign w_is_qword = (r_k >= LP_K_CH0) && !w_is_csum;
    assign w_cfg_sel  = (r_k < 7'd12) ? r_k[4:0] : (r_k[4:0] + 5'd3);
    assign w_last_ch  = ((r_ch + 6'd1) == r_qch);
    assign o_error    = r_error;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_k     <= '0;
            r_qch   <= '0;
            r_ch    <= '0;
            r_data  <= '0;
            r_error <= 1'b0;
`ifdef FS_CFG_LOADER_CHECKSUM_EN
            r_xor   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_base  <= w_base_next;
            r_k     <= w_k_next;
            r_qch   <= w_qch_next;
            r_ch    <= w_ch_next;
            r_data  <= w_data_next;
            r_error <= w_error_next;
`ifdef FS_CFG_LOADER_CHECKSUM_EN
            r_xor   <= w_xor_next;
`endif
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_base_next   = r_base;
        w_k_next      = r_k;
        w_qch_next    = r_qch;
        w_ch_next     = r_ch;
        w_data_next   = r_data;
        w_error_next  = r_error;
`ifdef FS_CFG_LOADER_CHECKSUM_EN
        w_xor_next    = r_xor;
`endif
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_addr    = '0;
        o_config_wen  = 1'b0;
        o_config_sel  = '0;
        o_config_data = '0;

        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_base_next  = i_desc_base_addr;
                    w_k_next     = '0;
                    w_qch_next   = '0;
                    w_ch_next    = '0;
                    w_error_next = 1'b0;
`ifdef FS_CFG_LOADER_CHECKSUM_EN
                    w_xor_next   = '0;
`endif
                    w_state_next = S_REQ;
                end
            end

            S_REQ: begin
                o_busy     = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_addr = r_base + LP_STRIDE * {25'd0, r_k};
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (i_mem_ready) begin
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (i_mem_rvalid) begin
                    w_data_next  = i_mem_rdata;
`ifdef FS_CFG_LOADER_CHECKSUM_EN
                    if (!w_is_csum) begin
                        w_xor_next = r_xor ^ i_mem_rdata;
                    end
`endif
                    w_state_next = S_WR;
                end
            end

            S_WR: begin
                o_busy = 1'b1;
                if (w_is_cfg) begin
                    o_config_wen  = 1'b1;
                    o_config_sel  = w_cfg_sel;
                    o_config_data = r_data;
                end else if (w_is_qword) begin
                    // Odd word indices past 16 are multipliers, even ones are shifts.
                    o_config_wen  = 1'b1;
                    o_config_sel  = r_k[0] ? 5'd13 : 5'd14;
                    o_config_data = r_data;
                end

                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_k_next = r_k + 7'd1;
                    if (w_is_cfg) begin
                        w_state_next = S_REQ;
                    end else if (r_k == LP_K_QCH) begin
                        w_qch_next = r_data[5:0];
                        if (r_data[5:0] > LP_MAX_QCH) begin
                            w_error_next = 1'b1;
                            w_state_next = S_DONE;
                        end else if (r_data[5:0] == 6'd0) begin
`ifdef FS_CFG_LOADER_CHECKSUM_EN
                            w_state_next = S_REQ;
`else
                            w_state_next = S_DONE;
`endif
                        end else begin
                            w_state_next = S_QIDX;
                        end
                    end else if (w_is_csum) begin
`ifdef FS_CFG_LOADER_CHECKSUM_EN
                        if (r_data != r_xor) begin
                            w_error_next = 1'b1;
                        end
`endif
                        w_state_next = S_DONE;
                    end else if (r_k[0]) begin
                        w_state_next = S_REQ;
                    end else begin
                        w_ch_next = r_ch + 6'd1;
                        if (!w_last_ch) begin
                            w_state_next = S_QIDX;
                        end else begin
`ifdef FS_CFG_LOADER_CHECKSUM_EN
                            w_state_next = S_REQ;
`else
                            w_state_next = S_DONE;
`endif
                        end
                    end
                end
            end

            S_QIDX: begin
                o_busy        = 1'b1;
                o_config_wen  = 1'b1;
                o_config_sel  = 5'd12;
                o_config_data = {26'd0, r_ch};
                w_state_next  = i_abort ? S_IDLE : S_REQ;
            end

            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fs_accel_config_loader.sv
// Directed bench for fs_accel_config_loader: a descriptor model predicts every write and read.
module tb_fs_accel_config_loader;

    localparam int MAXQ = 36;
`ifdef FS_CFG_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_resetn;
    logic        i_start;
    logic        i_abort;
    logic [31:0] i_desc_base_addr;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_config_wen;
    logic [4:0]  o_config_sel;
    logic [31:0] o_config_data;

    fs_accel_config_loader dut (
        .i_clk            (i_clk),
        .i_resetn         (i_resetn),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_desc_base_addr (i_desc_base_addr),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_error          (o_error),
        .o_mem_req        (o_mem_req),
        .o_mem_addr       (o_mem_addr),
        .i_mem_ready      (i_mem_ready),
        .i_mem_rvalid     (i_mem_rvalid),
        .i_mem_rdata      (i_mem_rdata),
        .o_config_wen     (o_config_wen),
        .o_config_sel     (o_config_sel),
        .o_config_data    (o_config_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] desc [0:127];
    logic [31:0] cur_base;
    int          stall_cfg;
    bit          exp_err;
    int          wr_cnt, rd_cnt, done_cnt, sel12_cnt;
    logic [31:0] last_addr, first_addr;
    bit          seen_ch1;
    bit          pend;
    logic [31:0] pend_addr;
    int          wait_cnt;
    bit          prev_wait;
    logic [31:0] prev_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - cur_base;
        if (off[31:9] == 23'd0) return desc[off[8:2]];
        return 32'hBAD0_BAD0;
    endfunction

    // Checker and memory responder, evaluated once per cycle on the falling edge.
    task automatic monitor();
        wr_t e;
        logic [31:0] ea;
        if (!i_resetn) begin
            pend = 0; wait_cnt = 0; prev_wait = 0;
            i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
            return;
        end
        if (o_config_wen) begin
            wr_cnt++;
            if (o_config_sel == 5'd12) begin
                sel12_cnt++;
                if (o_config_data == 32'd1) seen_ch1 = 1;
            end
            if (exp_wr.size() == 0) fail_now("wr_unexpected");
            else begin
                e = exp_wr.pop_front();
                chk("wr_sel", 64'(o_config_sel), 64'(e.sel));
                chk("wr_data", 64'(o_config_data), 64'(e.data));
            end
        end else begin
            chk("cfg_zero_when_idle", {27'd0, o_config_sel, o_config_data}, 64'd0);
        end
        if (o_done) begin
            done_cnt++;
            chk("done_error", 64'(o_error), 64'(exp_err));
            chk("done_writes_left", 64'(exp_wr.size()), 64'd0);
            chk("done_reads_left", 64'(exp_rd.size()), 64'd0);
        end
        if (o_mem_req && prev_wait) chk("req_addr_stable", 64'(o_mem_addr), 64'(prev_addr));
        i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0; prev_wait = 0;
        if (pend) begin
            i_mem_rvalid = 1;
            i_mem_rdata  = mem_word(pend_addr);
            pend = 0;
        end else if (o_mem_req) begin
            if (wait_cnt >= stall_cfg) begin
                i_mem_ready = 1; pend = 1; pend_addr = o_mem_addr; wait_cnt = 0;
                rd_cnt++;
                if (rd_cnt == 1) first_addr = o_mem_addr;
                last_addr = o_mem_addr;
                if (exp_rd.size() == 0) fail_now("rd_unexpected");
                else begin
                    ea = exp_rd.pop_front();
                    chk("rd_addr", 64'(o_mem_addr), 64'(ea));
                end
            end else begin
                wait_cnt++; prev_wait = 1; prev_addr = o_mem_addr;
            end
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        monitor();
        #1;
    endtask

    // Descriptor model: builds memory contents and the expected read/write streams.
    task automatic prepare(input logic [31:0] base, input int qch, input bit corrupt);
        int n_fetch, n_rd;
        logic [31:0] x;
        cur_base = base;
        exp_wr.delete(); exp_rd.delete();
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; sel12_cnt = 0; seen_ch1 = 0;
        last_addr = '0; first_addr = '0; wait_cnt = 0; prev_wait = 0;
        for (int k = 0; k < 128; k++) desc[k] = 32'h5A00_0000 ^ (32'(k) * 32'h0001_0203);
        desc[16] = 32'h1234_56C0 | 32'(qch);   // bits [7:6] set; only [5:0] is the count
        n_fetch = 17 + ((qch <= MAXQ) ? 2 * qch : 0);
        n_rd    = n_fetch;
        exp_err = (qch > MAXQ);
        if (CS && qch <= MAXQ) begin
            x = '0;
            for (int k = 0; k < n_fetch; k++) x ^= desc[k];
            desc[n_fetch] = x;
            n_rd++;
            if (corrupt) begin
                desc[5] ^= 32'h0000_0100;
                exp_err = 1;
            end
        end
        for (int k = 0; k < 16; k++)
            exp_wr.push_back('{sel: (k < 12) ? 5'(k) : 5'(k + 3), data: desc[k]});
        if (qch <= MAXQ) begin
            for (int ch = 0; ch < qch; ch++) begin
                exp_wr.push_back('{sel: 5'd12, data: 32'(ch)});
                exp_wr.push_back('{sel: 5'd13, data: desc[17 + 2 * ch]});
                exp_wr.push_back('{sel: 5'd14, data: desc[18 + 2 * ch]});
            end
        end
        for (int k = 0; k < n_rd; k++) exp_rd.push_back(base + 32'(k) * 32'd4);
    endtask

    task automatic start_load();
        i_desc_base_addr = cur_base;
        i_start = 1;
        tick();
        i_start = 0;
        i_desc_base_addr = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input int limit);
        bit got;
        got = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done_cnt > 0) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_load(input logic [31:0] base, input int qch, input int stall,
                            input bit restart, input bit corrupt, input int exp_wr_n,
                            input int exp_rd_n, input logic [31:0] exp_last, input bit exp_err_lit);
        prepare(base, qch, corrupt);
        stall_cfg = stall;
        start_load();
        if (restart) begin
            repeat (6) tick();
            chk("busy_before_restart", 64'(o_busy), 64'd1);
            i_desc_base_addr = 32'h0BAD_0000;
            i_start = 1;
            tick();
            i_start = 0;
        end
        wait_done(3000);
        repeat (4) tick();
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("write_count", 64'(wr_cnt), 64'(exp_wr_n));
        chk("read_count", 64'(rd_cnt), 64'(exp_rd_n));
        chk("first_addr", 64'(first_addr), 64'(base));
        chk("last_addr", 64'(last_addr), 64'(exp_last));
        chk("error_sticky", 64'(o_error), 64'(exp_err_lit));
        chk("busy_after", 64'(o_busy), 64'd0);
        if (qch == 0 || qch > MAXQ) chk("no_sel12", 64'(sel12_cnt), 64'd0);
        $display("load base=0x%08h qch=%0d stall=%0d: writes=%0d reads=%0d last=0x%08h error=%0b",
                 base, qch, stall, wr_cnt, rd_cnt, last_addr, o_error);
    endtask

    initial begin
        i_resetn = 0; i_start = 0; i_abort = 0; i_desc_base_addr = '0;
        i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
        cur_base = '0; stall_cfg = 0; exp_err = 0; pend = 0;
        #1;
        chk("reset_ctl", {58'd0, o_busy, o_done, o_error, o_mem_req, o_config_wen, 1'b0}, 64'd0);
        chk("reset_addr_sel_data", {o_mem_addr, o_config_data} | 64'(o_config_sel), 64'd0);
        repeat (3) tick();
        i_resetn = 1;
        tick();

        run_load(32'h0000_1000, 3, 0, 0, 0, 25, CS ? 24 : 23, CS ? 32'h0000_105C : 32'h0000_1058, 0);
        run_load(32'hFFFF_FFE0, 0, 0, 0, 0, 16, CS ? 18 : 17, CS ? 32'h0000_0024 : 32'h0000_0020, 0);
        run_load(32'h0000_3000, 37, 0, 0, 0, 16, 17, 32'h0000_3040, 1);
        run_load(32'h0000_4000, 1, 5, 1, 0, 19, CS ? 20 : 19, CS ? 32'h0000_404C : 32'h0000_4048, 0);

        // Abort while channel 1 is being loaded.
        prepare(32'h0000_5000, 3, 0);
        stall_cfg = 0;
        start_load();
        for (int i = 0; i < 500 && !seen_ch1; i++) tick();
        chk("abort_reached_ch1", 64'(seen_ch1), 64'd1);
        i_abort = 1;
        tick();
        i_abort = 0;
        chk("abort_busy", 64'(o_busy), 64'd0);
        exp_wr.delete(); exp_rd.delete();
        repeat (10) tick();
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_error", 64'(o_error), 64'd0);
        $display("abort at channel 1: writes=%0d done=%0d busy=%0b", wr_cnt, done_cnt, o_busy);

        // Reset in the middle of a load.
        prepare(32'h0000_6000, 3, 0);
        start_load();
        repeat (15) tick();
        chk("busy_before_reset", 64'(o_busy), 64'd1);
        i_resetn = 0;
        #1;
        chk("midreset_ctl", {59'd0, o_busy, o_done, o_error, o_mem_req, o_config_wen}, 64'd0);
        chk("midreset_addr_data", {o_mem_addr, o_config_data}, 64'd0);
        chk("midreset_sel", 64'(o_config_sel), 64'd0);
        repeat (3) tick();
        i_resetn = 1;
        tick();
        $display("reset mid-load: outputs cleared");
        run_load(32'h0000_6000, 0, 0, 0, 0, 16, CS ? 18 : 17, CS ? 32'h0000_6044 : 32'h0000_6040, 0);

        // Start and abort together in IDLE: abort wins.
        prepare(32'h0000_9000, 0, 0);
        i_desc_base_addr = cur_base;
        i_start = 1; i_abort = 1;
        tick();
        i_start = 0; i_abort = 0;
        chk("start_abort_busy", 64'(o_busy), 64'd0);
        repeat (5) tick();
        chk("start_abort_reads", 64'(rd_cnt), 64'd0);
        chk("start_abort_done", 64'(done_cnt), 64'd0);
        exp_wr.delete(); exp_rd.delete();
        $display("start+abort same cycle: reads=%0d busy=%0b", rd_cnt, o_busy);

`ifdef FS_CFG_LOADER_CHECKSUM_EN
        run_load(32'h0000_8000, 3, 0, 0, 1, 25, 24, 32'h0000_805C, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
